// File: rtl/microseq.sv
// microseq: microcode sequencer. A registered micro-program counter addresses an external
// microcode ROM. Each microword runs for two cycles: a setup cycle (phase 0) and a commit
// cycle (phase 1). At commit, the next-address control (NAC) field picks the next uPC.
//
// Microword layout: [UW-1:AW+4] control, [AW+3] BRK, [AW+2:AW] NAC, [AW-1:0] NA.
//
// Optional feature macro: MICROSEQ_BREAK_EN enables the BRK bit, the BRK state, cont_i and brk_o.
// When it is undefined, the BRK bit is ignored, cont_i is unused and brk_o is tied to 0.
//
// Ports:
//   clk          clock; all state changes on its rising edge
//   reset        synchronous, active-high reset
//   opcode_i     IR opcode, used by DISP
//   cond_i       flag condition, used by CJMP
//   ready_i      memory ready; WAITR holds phase 0 while it is low
//   irq_i        level interrupt request, sampled only on a FETCH commit
//   fault_i      level fault request; vectors to FAULT_VEC
//   cont_i       leave the BRK state
//   uword_i      ROM data, combinational from uaddr_o
//   uaddr_o      registered uPC
//   ctrl_o       control field; 0 in BRK or while reset is high
//   phase_o      0 = setup cycle, 1 = commit cycle
//   irq_ack_o    one-cycle pulse in the first cycle at IRQ_VEC
//   stack_err_o  sticky return-stack overflow/underflow flag
//   brk_o        high while in BRK
module microseq #(
  parameter int unsigned UW          = 48,
  parameter int unsigned AW          = 8,
  parameter int unsigned OPW         = 6,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_VEC   = 0,
  parameter int unsigned IRQ_VEC     = 1,
  parameter int unsigned FETCH_VEC   = 2,
  parameter int unsigned FAULT_VEC   = 3,
  localparam int unsigned CW         = UW - AW - 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode_i,
  input  logic           cond_i,
  input  logic           ready_i,
  input  logic           irq_i,
  input  logic           fault_i,
  input  logic           cont_i,
  input  logic [UW-1:0]  uword_i,
  output logic [AW-1:0]  uaddr_o,
  output logic [CW-1:0]  ctrl_o,
  output logic           phase_o,
  output logic           irq_ack_o,
  output logic           stack_err_o,
  output logic           brk_o
);

  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);

  localparam logic [2:0] NacSeq   = 3'd0;
  localparam logic [2:0] NacJmp   = 3'd1;
  localparam logic [2:0] NacDisp  = 3'd2;
  localparam logic [2:0] NacCjmp  = 3'd3;
  localparam logic [2:0] NacCall  = 3'd4;
  localparam logic [2:0] NacRet   = 3'd5;
  localparam logic [2:0] NacWaitr = 3'd6;
  localparam logic [2:0] NacFetch = 3'd7;

  localparam logic [AW-1:0] ResetVec = AW'(RESET_VEC);
  localparam logic [AW-1:0] IrqVec   = AW'(IRQ_VEC);
  localparam logic [AW-1:0] FetchVec = AW'(FETCH_VEC);
  localparam logic [AW-1:0] FaultVec = AW'(FAULT_VEC);

  logic [AW-1:0]  upc_q, upc_d;
  logic           phase_q, phase_d;
  logic           irq_ack_q, irq_ack_d;
  logic           stack_err_q, stack_err_d;
  logic [SpW-1:0] sp_q, sp_d;
  // Shift-register stack: entry 0 is the top of stack.
  logic [AW-1:0]  stack_q [STACK_DEPTH];
  logic [AW-1:0]  stack_d [STACK_DEPTH];

  logic           in_brk;
  logic           brk_d;
  logic           brk_bit;
  logic           cont;

  logic [2:0]     nac;
  logic [AW-1:0]  na;
  logic [AW-1:0]  upc_inc;
  logic           commit;
  logic           stk_full;
  logic           stk_empty;
  logic           stk_fault;

  assign nac       = uword_i[AW+2:AW];
  assign na        = uword_i[AW-1:0];
  assign upc_inc   = upc_q + AW'(1);
  assign commit    = phase_q && !in_brk;
  assign stk_full  = (sp_q == SpW'(STACK_DEPTH));
  assign stk_empty = (sp_q == '0);
  assign stk_fault = commit && (((nac == NacCall) && stk_full) ||
                                ((nac == NacRet) && stk_empty));

`ifdef MICROSEQ_BREAK_EN
  localparam logic StRun = 1'b0;
  localparam logic StBrk = 1'b1;

  logic state_q, state_d;

  assign brk_bit = uword_i[AW+3];
  assign cont    = cont_i;
  assign in_brk  = (state_q == StBrk);

  always_comb begin
    state_d = brk_d ? StBrk : StRun;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end
`else
  logic unused_brk;

  assign brk_bit    = 1'b0;
  assign cont       = 1'b0;
  assign in_brk     = 1'b0;
  assign unused_brk = ^{cont_i, uword_i[AW+3], brk_d};
`endif

  // Priority: fault_i > stack error > BRK bit > NAC. Reset is handled in the flops.
  always_comb begin
    upc_d       = upc_q;
    phase_d     = phase_q;
    brk_d       = in_brk;
    irq_ack_d   = 1'b0;
    stack_err_d = stack_err_q;
    sp_d        = sp_q;
    stack_d     = stack_q;

    if (fault_i) begin
      upc_d   = FaultVec;
      phase_d = 1'b0;
      brk_d   = 1'b0;
      sp_d    = '0;
    end else if (stk_fault) begin
      upc_d       = FaultVec;
      phase_d     = 1'b0;
      brk_d       = 1'b0;
      sp_d        = '0;
      stack_err_d = 1'b1;
    end else if (in_brk) begin
      // phase_q is already 0 here, so execution resumes at the setup cycle.
      if (cont) begin
        brk_d = 1'b0;
      end
    end else if (!phase_q) begin
      if (!((nac == NacWaitr) && !ready_i)) begin
        phase_d = 1'b1;
      end
    end else begin
      phase_d = 1'b0;
      brk_d   = brk_bit;
      case (nac)
        NacSeq, NacWaitr: upc_d = upc_inc;
        NacJmp:           upc_d = na;
        NacDisp:          upc_d = na + AW'(opcode_i);
        NacCjmp:          upc_d = cond_i ? na : upc_inc;
        NacCall: begin
          upc_d      = na;
          sp_d       = sp_q + SpW'(1);
          stack_d[0] = upc_inc;
          for (int i = 1; i < int'(STACK_DEPTH); i++) begin
            stack_d[i] = stack_q[i-1];
          end
        end
        NacRet: begin
          upc_d = stack_q[0];
          sp_d  = sp_q - SpW'(1);
          for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) begin
            stack_d[i] = stack_q[i+1];
          end
        end
        default: begin
          if (irq_i) begin
            upc_d     = IrqVec;
            irq_ack_d = 1'b1;
          end else begin
            upc_d = FetchVec;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q       <= ResetVec;
      phase_q     <= 1'b0;
      irq_ack_q   <= 1'b0;
      stack_err_q <= 1'b0;
      sp_q        <= '0;
    end else begin
      upc_q       <= upc_d;
      phase_q     <= phase_d;
      irq_ack_q   <= irq_ack_d;
      stack_err_q <= stack_err_d;
      sp_q        <= sp_d;
    end
  end

  // Stack contents need no reset; sp_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign uaddr_o     = upc_q;
  assign phase_o     = phase_q;
  assign irq_ack_o   = irq_ack_q;
  assign stack_err_o = stack_err_q;
  assign brk_o       = in_brk;
  assign ctrl_o      = (reset || in_brk) ? '0 : uword_i[UW-1:AW+4];

endmodule
